dm_wait: RTL and testbench

- Parametrised data-memory block with a request/ready handshake, configurable wait states, automatic load extension and alignment/range error reporting.
- Sits in the MEM stage of the pipelined CPU, or behind a bus bridge, as the next generation of the single-cycle data memory.
- Byte lanes are derived internally from size and address, so the requester does not supply byte enables.
- Memory clear is a sequential sweep (one word per cycle), not a single-cycle array reset.

---
 rtl/dm_wait.sv | 209 ++++++++++++++++++++
 tb/tb_dm_wait.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dm_wait.sv
// Data memory with request/ready handshake, programmable wait states,
// load extension, alignment/range error reporting and a sequential clear sweep.
module dm_wait #(
  parameter int unsigned DEPTH        = 4096,
  parameter int unsigned WAIT         = 2,
  parameter int unsigned CLEAR_ON_RST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic        ready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        init_done
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic [2:0] {S_CLR, S_IDLE, S_WAIT, S_ACC, S_RESP} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   clr_idx_q, clr_idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   widx_q, widx_d;
  logic [1:0]      boff_q, boff_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [31:0]     wd_q, wd_d;
  logic            ready_q, ready_d;
  logic            rvalid_q, rvalid_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            init_done_q, init_done_d;

  logic [31:0]     mem_q [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [31:0]     mem_wdata;

  logic            req_err;
  logic [31:0]     rd_word;
  logic [31:0]     rd_shift;
  logic [15:0]     rd_half;
  logic [31:0]     ld_ext;
  logic [3:0]      lane_mask;
  logic [31:0]     wd_rep;
  logic [31:0]     st_merge;

  // Error classification of the incoming request
  always_comb begin
    req_err = 1'b0;
    if (size == 2'b11)                           req_err = 1'b1;
    if (size == 2'b01 && addr[0])                req_err = 1'b1;
    if (size == 2'b10 && addr[1:0] != 2'b00)     req_err = 1'b1;
    if (addr[31:2] >= 30'(DEPTH))                req_err = 1'b1;
  end

  // Load extension and store lane merge for the latched request
  always_comb begin
    rd_word  = mem_q[widx_q];
    rd_shift = rd_word >> {boff_q, 3'b000};
    rd_half  = boff_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'h0, rd_shift[7:0]} : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   ld_ext = uns_q ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: ld_ext = rd_word;
    endcase
    case (size_q)
      2'b00: begin
        lane_mask = 4'b0001 << boff_q;
        wd_rep    = {4{wd_q[7:0]}};
      end
      2'b01: begin
        lane_mask = boff_q[1] ? 4'b1100 : 4'b0011;
        wd_rep    = {2{wd_q[15:0]}};
      end
      default: begin
        lane_mask = 4'b1111;
        wd_rep    = wd_q;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      st_merge[8*i +: 8] = lane_mask[i] ? wd_rep[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    clr_idx_d   = clr_idx_q;
    cnt_d       = cnt_q;
    widx_d      = widx_q;
    boff_d      = boff_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    wd_d        = wd_q;
    rdata_d     = rdata_q;
    err_d       = 1'b0;
    init_done_d = init_done_q;
    mem_we      = 1'b0;
    mem_waddr   = widx_q;
    mem_wdata   = st_merge;

    case (state_q)
      S_CLR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_idx_q;
        mem_wdata = 32'h0;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == AW'(DEPTH - 1)) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
      end
      S_IDLE: begin
        rdata_d = 32'h0;
        if (req) begin
          widx_d = addr[AW+1:2];
          boff_d = addr[1:0];
          we_d   = we;
          size_d = size;
          uns_d  = uns;
          wd_d   = wd;
          if (req_err) begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end else if (WAIT == 0) begin
            state_d = S_ACC;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(WAIT);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= CW'(1)) state_d = S_ACC;
        else                 cnt_d   = cnt_q - 1'b1;
      end
      S_ACC: begin
        state_d = S_RESP;
        if (we_q) mem_we  = 1'b1;
        else      rdata_d = ld_ext;
      end
      S_RESP: begin
        state_d = S_IDLE;
        rdata_d = 32'h0;
      end
      default: state_d = S_IDLE;
    endcase

    ready_d  = (state_d == S_IDLE);
    rvalid_d = (state_d == S_RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= (CLEAR_ON_RST != 0) ? S_CLR : S_IDLE;
      clr_idx_q   <= '0;
      cnt_q       <= '0;
      widx_q      <= '0;
      boff_q      <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      wd_q        <= '0;
      ready_q     <= (CLEAR_ON_RST == 0);
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      init_done_q <= (CLEAR_ON_RST == 0);
    end else begin
      state_q     <= state_d;
      clr_idx_q   <= clr_idx_d;
      cnt_q       <= cnt_d;
      widx_q      <= widx_d;
      boff_q      <= boff_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      wd_q        <= wd_d;
      ready_q     <= ready_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      init_done_q <= init_done_d;
    end
  end

  // Storage array; a reset edge suppresses any pending write
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign ready     = ready_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign err       = err_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_dm_wait.sv
// Directed bench for dm_wait: one instance with WAIT=2 and one with WAIT=0, both DEPTH=16.
module tb_dm_wait;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_a, we_a, uns_a, req_z, we_z, uns_z;
  logic [1:0]  size_a, size_z;
  logic [31:0] addr_a, wd_a, addr_z, wd_z;
  logic        ready_a, rvalid_a, err_a, init_a;
  logic        ready_z, rvalid_z, err_z, init_z;
  logic [31:0] rdata_a, rdata_z;

  dm_wait #(.DEPTH(16), .WAIT(2), .CLEAR_ON_RST(1)) u_dut_a (
    .clk(clk), .rst(rst), .req(req_a), .we(we_a), .size(size_a), .uns(uns_a),
    .addr(addr_a), .wd(wd_a), .ready(ready_a), .rvalid(rvalid_a), .rdata(rdata_a),
    .err(err_a), .init_done(init_a)
  );

  dm_wait #(.DEPTH(16), .WAIT(0), .CLEAR_ON_RST(1)) u_dut_z (
    .clk(clk), .rst(rst), .req(req_z), .we(we_z), .size(size_z), .uns(uns_z),
    .addr(addr_z), .wd(wd_z), .ready(ready_z), .rvalid(rvalid_z), .rdata(rdata_z),
    .err(err_z), .init_done(init_z)
  );

  localparam logic [1:0] SB = 2'd0, SH = 2'd1, SW = 2'd2, SX = 2'd3;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic f_ready(input int w);
    return (w == 0) ? ready_a : ready_z;
  endfunction
  function automatic logic f_rvalid(input int w);
    return (w == 0) ? rvalid_a : rvalid_z;
  endfunction
  function automatic logic f_err(input int w);
    return (w == 0) ? err_a : err_z;
  endfunction
  function automatic logic [31:0] f_rdata(input int w);
    return (w == 0) ? rdata_a : rdata_z;
  endfunction

  task automatic drive(input int w, input logic r, input logic we, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] d);
    if (w == 0) begin
      req_a = r; we_a = we; size_a = sz; uns_a = u; addr_a = a; wd_a = d;
    end else begin
      req_z = r; we_z = we; size_z = sz; uns_z = u; addr_z = a; wd_z = d;
    end
  endtask

  // Waits for ready, presents the request and returns just after the accepting edge
  task automatic accept(input int w, input string nm, input logic we, input logic [1:0] sz,
                        input logic u, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    while (!f_ready(w) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!f_ready(w)) chk({nm, ".ready_timeout"}, 64'(f_ready(w)), 64'd1);
    drive(w, 1'b1, we, sz, u, a, d);
    @(posedge clk);
    #1 drive(w, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic finish(input int w, input string nm, input logic [31:0] exp_rd,
                        input logic exp_err, input int exp_lat);
    int   lat = 0;
    logic busy_ready = 1'b0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (f_ready(w)) busy_ready = 1'b1;
      if (f_rvalid(w)) break;
    end
    chk({nm, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, ".err"}, 64'(f_err(w)), 64'(exp_err));
    chk({nm, ".rdata"}, 64'(f_rdata(w)), 64'(exp_rd));
    chk({nm, ".ready_while_busy"}, 64'(busy_ready), 64'd0);
    @(negedge clk);
    chk({nm, ".idle_outputs"}, {29'h0, f_rvalid(w), f_ready(w), f_err(w), f_rdata(w)},
        {29'h0, 1'b0, 1'b1, 1'b0, 32'h0});
  endtask

  task automatic xact(input int w, input string nm, input logic we, input logic [1:0] sz,
                      input logic u, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    accept(w, nm, we, sz, u, a, d);
    finish(w, nm, exp_rd, exp_err, exp_lat);
  endtask

  // Releases reset at a negedge and checks the clear sweep length and rvalid silence
  task automatic wait_clear(input string nm);
    int   na = 0, nz = 0, guard = 0;
    logic early = 1'b0, rv = 1'b0;
    while (!(ready_a && ready_z) && guard < 100) begin
      if (!ready_a) na++;
      if (!ready_z) nz++;
      if ((!ready_a && init_a) || (!ready_z && init_z)) early = 1'b1;
      if (rvalid_a || rvalid_z) rv = 1'b1;
      @(negedge clk);
      guard++;
    end
    chk({nm, ".clear_cycles_a"}, 64'(na), 64'd16);
    chk({nm, ".clear_cycles_z"}, 64'(nz), 64'd16);
    chk({nm, ".init_early"}, 64'(early), 64'd0);
    chk({nm, ".rvalid_during_clear"}, 64'(rv), 64'd0);
    chk({nm, ".init_done"}, {62'h0, init_a, init_z}, 64'h3);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);

    vq.push_back('{1'b0, SW, 1'b0, 32'h3C, 32'h0,        32'h00000000, 1'b0});
    vq.push_back('{1'b1, SW, 1'b0, 32'h08, 32'h80FF7F01, 32'h00000000, 1'b0});
    vq.push_back('{1'b0, SW, 1'b0, 32'h08, 32'h0,        32'h80FF7F01, 1'b0});
    vq.push_back('{1'b0, SB, 1'b0, 32'h0B, 32'h0,        32'hFFFFFF80, 1'b0});
    vq.push_back('{1'b0, SB, 1'b1, 32'h0B, 32'h0,        32'h00000080, 1'b0});
    vq.push_back('{1'b0, SB, 1'b0, 32'h09, 32'h0,        32'h0000007F, 1'b0});
    vq.push_back('{1'b0, SH, 1'b0, 32'h0A, 32'h0,        32'hFFFF80FF, 1'b0});
    vq.push_back('{1'b0, SH, 1'b1, 32'h08, 32'h0,        32'h00007F01, 1'b0});
    vq.push_back('{1'b1, SB, 1'b0, 32'h09, 32'h123456AA, 32'h00000000, 1'b0});
    vq.push_back('{1'b0, SW, 1'b0, 32'h08, 32'h0,        32'h80FFAA01, 1'b0});
    vq.push_back('{1'b1, SH, 1'b0, 32'h0A, 32'hFFFF1234, 32'h00000000, 1'b0});
    vq.push_back('{1'b0, SW, 1'b0, 32'h08, 32'h0,        32'h1234AA01, 1'b0});
    vq.push_back('{1'b1, SW, 1'b0, 32'h00, 32'h11112222, 32'h00000000, 1'b0});
    vq.push_back('{1'b1, SW, 1'b0, 32'h04, 32'h33334444, 32'h00000000, 1'b0});
    vq.push_back('{1'b0, SW, 1'b0, 32'h06, 32'h0,        32'h00000000, 1'b1});
    vq.push_back('{1'b1, SW, 1'b0, 32'h06, 32'hFFFFFFFF, 32'h00000000, 1'b1});
    vq.push_back('{1'b1, SH, 1'b0, 32'h05, 32'hFFFFAAAA, 32'h00000000, 1'b1});
    vq.push_back('{1'b1, SX, 1'b0, 32'h00, 32'hFFFFFFFF, 32'h00000000, 1'b1});
    vq.push_back('{1'b1, SW, 1'b0, 32'h40, 32'hFFFFFFFF, 32'h00000000, 1'b1});
    vq.push_back('{1'b0, SB, 1'b1, 32'h41, 32'h0,        32'h00000000, 1'b1});
    vq.push_back('{1'b0, SW, 1'b0, 32'h00, 32'h0,        32'h11112222, 1'b0});
    vq.push_back('{1'b0, SW, 1'b0, 32'h04, 32'h0,        32'h33334444, 1'b0});
    vq.push_back('{1'b1, SB, 1'b0, 32'h3F, 32'h000000C3, 32'h00000000, 1'b0});
    vq.push_back('{1'b0, SW, 1'b0, 32'h3C, 32'h0,        32'hC3000000, 1'b0});
    vq.push_back('{1'b0, SB, 1'b0, 32'h3F, 32'h0,        32'hFFFFFFC3, 1'b0});

    // Reset values while rst is held
    repeat (2) @(negedge clk);
    chk("reset_a", {29'h0, ready_a, rvalid_a, err_a, init_a, rdata_a}, 64'h0);
    chk("reset_z", {29'h0, ready_z, rvalid_z, err_z, init_z, rdata_z}, 64'h0);
    rst = 1'b0;
    wait_clear("por");

    foreach (vq[i]) begin
      xact(0, $sformatf("vec%0d", i), vq[i].we, vq[i].size, vq[i].uns, vq[i].addr, vq[i].wd,
           vq[i].exp_rdata, vq[i].exp_err, vq[i].exp_err ? 1 : 4);
    end

    // Reset during the wait phase of a store on the WAIT=2 instance
    accept(0, "rst_wait", 1'b1, SW, 1'b0, 32'h04, 32'hDEADBEEF);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_clear("rst_wait");
    xact(0, "rst_wait.lw4", 1'b0, SW, 1'b0, 32'h04, 32'h0, 32'h00000000, 1'b0, 4);
    xact(0, "rst_wait.lw8", 1'b0, SW, 1'b0, 32'h08, 32'h0, 32'h00000000, 1'b0, 4);

    // WAIT=0 instance: two-cycle latency, errors still one cycle
    xact(1, "z.sw4", 1'b1, SW, 1'b0, 32'h04, 32'hDEADBEEF, 32'h00000000, 1'b0, 2);
    xact(1, "z.lw4", 1'b0, SW, 1'b0, 32'h04, 32'h0, 32'hDEADBEEF, 1'b0, 2);
    xact(1, "z.lh6", 1'b0, SH, 1'b0, 32'h06, 32'h0, 32'hFFFFDEAD, 1'b0, 2);
    xact(1, "z.lbu4", 1'b0, SB, 1'b1, 32'h04, 32'h0, 32'h000000EF, 1'b0, 2);
    xact(1, "z.err", 1'b1, SW, 1'b0, 32'h41, 32'h0, 32'h00000000, 1'b1, 1);

    // Reset in the access cycle must suppress the write
    accept(1, "rst_acc", 1'b1, SW, 1'b0, 32'h08, 32'hCAFEF00D);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_clear("rst_acc");
    xact(1, "rst_acc.lw8", 1'b0, SW, 1'b0, 32'h08, 32'h0, 32'h00000000, 1'b0, 2);
    xact(1, "rst_acc.lw4", 1'b0, SW, 1'b0, 32'h04, 32'h0, 32'h00000000, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
